// File: rtl/std_nbdcache_data_port_pkg.sv
// ---------------------------------------------------------------------------
// std_nbdcache_data_port_pkg
//   Shared types and width helpers for the D-cache data-array request port.
//   - state_e      : controller state (array sweep vs. normal operation)
//   - idx_width()  : index width for an N-entry structure, never below 1 bit
//   - be_width()   : number of byte enables covering a data word
//   - cnt_width()  : width of an occupancy counter that must reach N
// ---------------------------------------------------------------------------
package std_nbdcache_data_port_pkg;

    typedef enum logic {
        STATE_INIT,
        STATE_READY
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int be_width(input int data_width, input int byte_width);
        return (data_width + byte_width - 1) / byte_width;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/std_nbdcache_data_port_resp_fifo.sv
// ---------------------------------------------------------------------------
// std_nbdcache_data_port_resp_fifo
//   Small synchronous FIFO holding read responses until the consumer takes
//   them. Push and pop in the same cycle is legal, including when full.
//
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset (empties the FIFO)
//   push_i/data_i  write one entry (ignored when full and not popping)
//   pop_i/data_o   head entry; pop_i removes it (ignored when empty)
//   count_o        current occupancy, 0..Depth
//   full_o/empty_o occupancy flags
// ---------------------------------------------------------------------------
module std_nbdcache_data_port_resp_fifo
    import std_nbdcache_data_port_pkg::*;
#(
    parameter int   Width    = 8,
    parameter int   Depth    = 2,
    localparam int  CntWidth = cnt_width(Depth)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic [Width-1:0]    data_i,
    input  logic                pop_i,
    output logic [Width-1:0]    data_o,
    output logic [CntWidth-1:0] count_o,
    output logic                full_o,
    output logic                empty_o
);

    localparam int                PtrWidth = idx_width(Depth);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [CntWidth-1:0] count_q;
    logic                do_push;
    logic                do_pop;

    assign full_o  = (count_q == CntWidth'(Depth));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: storage has no reset; only pointers and count need a defined
    // value, and leaving the array unreset keeps it a plain register file.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/std_nbdcache_data_port.sv
// ---------------------------------------------------------------------------
// std_nbdcache_data_port
//   Request-side controller for the multi-way D-cache data array. Accepts
//   read/write requests over valid/ready, drives the per-way single-port
//   SRAM interface (read latency 1) and returns read data through a
//   credit-protected response FIFO.
//
// Build option
//   STD_NBDCACHE_DATA_PORT_INIT_EN : when defined, every reset is followed by
//   a NumWords-cycle sweep writing zero to all ways; requests are refused and
//   init_done_o stays low until it completes. When undefined the block is
//   ready straight out of reset and init_done_o is tied high.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_*                 request channel (valid/ready, we, way mask, addr,
//                         wdata, byte enables)
//   resp_*                read response channel (valid/ready, originating
//                         way mask, per-way data zeroed for unmasked ways)
//   sram_req_o            per-way SRAM select
//   sram_we_o/addr/wdata/be  command shared by all ways
//   sram_rdata_i          per-way read data, one cycle after the request
//   init_done_o           array usable
// ---------------------------------------------------------------------------
module std_nbdcache_data_port
    import std_nbdcache_data_port_pkg::*;
#(
    parameter int  NumWords  = 1024,
    parameter int  DataWidth = 128,
    parameter int  ByteWidth = 8,
    parameter int  WAY_COUNT = 1,
    parameter int  RespDepth = 2,
    localparam int AddrWidth = idx_width(NumWords),
    localparam int BeWidth   = be_width(DataWidth, ByteWidth)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic                                req_we_i,
    input  logic [WAY_COUNT-1:0]                req_way_mask_i,
    input  logic [AddrWidth-1:0]                req_addr_i,
    input  logic [DataWidth-1:0]                req_wdata_i,
    input  logic [BeWidth-1:0]                  req_be_i,
    output logic                                resp_valid_o,
    input  logic                                resp_ready_i,
    output logic [WAY_COUNT-1:0]                resp_way_mask_o,
    output logic [WAY_COUNT-1:0][DataWidth-1:0] resp_rdata_o,
    output logic [WAY_COUNT-1:0]                sram_req_o,
    output logic                                sram_we_o,
    output logic [AddrWidth-1:0]                sram_addr_o,
    output logic [DataWidth-1:0]                sram_wdata_o,
    output logic [BeWidth-1:0]                  sram_be_o,
    input  logic [WAY_COUNT-1:0][DataWidth-1:0] sram_rdata_i,
    output logic                                init_done_o
);

    // Entry layout depends on module parameters, so it lives here.
    typedef struct packed {
        logic [WAY_COUNT-1:0]                way_mask;
        logic [WAY_COUNT-1:0][DataWidth-1:0] rdata;
    } resp_entry_t;

    localparam int CntWidth = cnt_width(RespDepth);

    state_e                 state;
    logic [AddrWidth-1:0]   sweep_addr;

    // ------------------------------------------------------------------
    // Optional zero-initialisation sweep
    // ------------------------------------------------------------------
`ifdef STD_NBDCACHE_DATA_PORT_INIT_EN
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumWords - 1);

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] init_addr_q, init_addr_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= STATE_INIT;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        case (state_q)
            STATE_INIT: begin
                if (init_addr_q == LastAddr) begin
                    state_d     = STATE_READY;
                    init_addr_d = '0;
                end else begin
                    init_addr_d = init_addr_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign state       = state_q;
    assign sweep_addr  = init_addr_q;
    assign init_done_o = (state_q == STATE_READY);
`else
    assign state       = STATE_READY;
    assign sweep_addr  = '0;
    assign init_done_o = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Request acceptance with response-buffer credit
    // ------------------------------------------------------------------
    logic                 pending_q;
    logic [WAY_COUNT-1:0] pending_mask_q;
    logic [CntWidth-1:0]  fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 read_credit;
    logic                 req_accept;
    logic                 read_accept;
    resp_entry_t          push_entry;
    resp_entry_t          head_entry;

    assign resp_valid_o = !fifo_empty;
    assign fifo_pop     = resp_valid_o && resp_ready_i;

    // A read issued now lands in the FIFO next cycle; it may go only if the
    // occupancy after this cycle's push (last read) and pop leaves room.
    assign read_credit = (int'(fifo_count) + int'(pending_q) - int'(fifo_pop)) < RespDepth;

    assign req_ready_o = !rst_i && (state == STATE_READY) && (req_we_i || read_credit);
    assign req_accept  = req_valid_i && req_ready_o;
    assign read_accept = req_accept && !req_we_i;

    // ------------------------------------------------------------------
    // SRAM command
    // ------------------------------------------------------------------
    always_comb begin
        sram_req_o   = '0;
        sram_we_o    = req_we_i;
        sram_addr_o  = req_addr_i;
        sram_wdata_o = req_wdata_i;
        sram_be_o    = req_be_i;
        if (rst_i) begin
            sram_req_o = '0;
        end else if (state == STATE_INIT) begin
            sram_req_o   = '1;
            sram_we_o    = 1'b1;
            sram_addr_o  = sweep_addr;
            sram_wdata_o = '0;
            sram_be_o    = '1;
        end else if (req_accept) begin
            sram_req_o = req_way_mask_i;
        end
    end

    // ------------------------------------------------------------------
    // Read capture: one cycle after the access, data is masked and pushed
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q      <= 1'b0;
            pending_mask_q <= '0;
        end else begin
            pending_q <= read_accept;
            if (read_accept) begin
                pending_mask_q <= req_way_mask_i;
            end
        end
    end

    always_comb begin
        push_entry          = '0;
        push_entry.way_mask = pending_mask_q;
        for (int w = 0; w < WAY_COUNT; w++) begin
            push_entry.rdata[w] = pending_mask_q[w] ? sram_rdata_i[w] : '0;
        end
    end

    std_nbdcache_data_port_resp_fifo #(
        .Width (($bits(resp_entry_t))),
        .Depth (RespDepth)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (pending_q),
        .data_i  (push_entry),
        .pop_i   (fifo_pop),
        .data_o  (head_entry),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign resp_way_mask_o = head_entry.way_mask;
    assign resp_rdata_o    = head_entry.rdata;

    // The credit check must make overflow impossible.
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(pending_q && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_std_nbdcache_data_port.sv
module tb_std_nbdcache_data_port;

    localparam int NW = 16;
    localparam int DW = 32;
    localparam int WC = 2;
`ifdef STD_NBDCACHE_DATA_PORT_INIT_EN
    localparam logic [DW-1:0] MEM_INIT = 32'hDEADBEEF;
`else
    localparam logic [DW-1:0] MEM_INIT = 32'h0;
`endif
    localparam logic [63:0] D3 = 64'hA5A5A5A5_00000000;
    localparam logic [63:0] D5 = 64'h00000000_FFFFFF00;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 req_valid_i = 1'b0;
    logic                 req_ready_o;
    logic                 req_we_i = 1'b0;
    logic [WC-1:0]        req_way_mask_i = '0;
    logic [3:0]           req_addr_i = '0;
    logic [DW-1:0]        req_wdata_i = '0;
    logic [3:0]           req_be_i = '0;
    logic                 resp_valid_o;
    logic                 resp_ready_i = 1'b1;
    logic [WC-1:0]        resp_way_mask_o;
    logic [WC-1:0][DW-1:0] resp_rdata_o;
    logic [WC-1:0]        sram_req_o;
    logic                 sram_we_o;
    logic [3:0]           sram_addr_o;
    logic [DW-1:0]        sram_wdata_o;
    logic [3:0]           sram_be_o;
    logic [WC-1:0][DW-1:0] sram_rdata_i;
    logic                 init_done_o;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    std_nbdcache_data_port #(
        .NumWords  (NW),
        .DataWidth (DW),
        .ByteWidth (8),
        .WAY_COUNT (WC),
        .RespDepth (2)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_we_i        (req_we_i),
        .req_way_mask_i  (req_way_mask_i),
        .req_addr_i      (req_addr_i),
        .req_wdata_i     (req_wdata_i),
        .req_be_i        (req_be_i),
        .resp_valid_o    (resp_valid_o),
        .resp_ready_i    (resp_ready_i),
        .resp_way_mask_o (resp_way_mask_o),
        .resp_rdata_o    (resp_rdata_o),
        .sram_req_o      (sram_req_o),
        .sram_we_o       (sram_we_o),
        .sram_addr_o     (sram_addr_o),
        .sram_wdata_o    (sram_wdata_o),
        .sram_be_o       (sram_be_o),
        .sram_rdata_i    (sram_rdata_i),
        .init_done_o     (init_done_o)
    );

    // Single-port SRAM per way, read latency 1, byte-granular writes.
    logic [DW-1:0] mem [WC][NW] = '{default: '{default: MEM_INIT}};
    logic [WC-1:0][DW-1:0] sram_rdata_q = '0;
    assign sram_rdata_i = sram_rdata_q;

    always @(posedge clk_i) begin
        for (int w = 0; w < WC; w++) begin
            if (sram_req_o[w]) begin
                if (sram_we_o) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sram_be_o[b]) mem[w][sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
                    end
                end else begin
                    sram_rdata_q[w] <= mem[w][sram_addr_o];
                end
            end
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_idle();
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_way_mask_i = '0;
    endtask

    task automatic drive_read(input logic [WC-1:0] mask, input logic [3:0] addr);
        req_valid_i    = 1'b1;
        req_we_i       = 1'b0;
        req_way_mask_i = mask;
        req_addr_i     = addr;
        req_wdata_i    = '0;
        req_be_i       = '0;
    endtask

    task automatic drive_write(input logic [WC-1:0] mask, input logic [3:0] addr,
                               input logic [DW-1:0] wdata, input logic [3:0] be);
        req_valid_i    = 1'b1;
        req_we_i       = 1'b1;
        req_way_mask_i = mask;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        req_be_i       = be;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_vec++;
`ifdef STD_NBDCACHE_DATA_PORT_INIT_EN
        if (req_ready_o !== 1'b0 || resp_valid_o !== 1'b0 || sram_req_o !== 2'b00 || init_done_o !== 1'b0) begin
`else
        if (req_ready_o !== 1'b0 || resp_valid_o !== 1'b0 || sram_req_o !== 2'b00 || init_done_o !== 1'b1) begin
`endif
            n_bad++;
            $display("FAIL reset_state: ready=%b valid=%b sram_req=%b init_done=%b", req_ready_o, resp_valid_o, sram_req_o, init_done_o);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic test_init();
`ifdef STD_NBDCACHE_DATA_PORT_INIT_EN
        for (int i = 0; i < NW; i++) begin
            @(negedge clk_i);
            n_vec++;
            if (sram_req_o !== 2'b11 || sram_we_o !== 1'b1 || sram_addr_o !== 4'(i) || sram_wdata_o !== '0 ||
                sram_be_o !== 4'hF || req_ready_o !== 1'b0 || init_done_o !== 1'b0) begin
                n_bad++;
                $display("FAIL init_sweep[%0d]: req=%b we=%b addr=%0d wdata=%h be=%h ready=%b done=%b, expected 11 1 %0d 0 f 0 0",
                         i, sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o, req_ready_o, init_done_o, i);
            end
            next_cycle();
        end
`endif
        @(negedge clk_i);
        n_vec++;
        if (init_done_o !== 1'b1 || req_ready_o !== 1'b1 || sram_req_o !== 2'b00) begin
            n_bad++;
            $display("FAIL init_done: done=%b ready=%b sram_req=%b, expected 1 1 00", init_done_o, req_ready_o, sram_req_o);
        end
        // A freshly initialised word reads back as zero on both ways.
        drive_read(2'b11, 4'd9);
        next_cycle();
        drive_idle();
        next_cycle();
        @(negedge clk_i);
        n_vec++;
        if (resp_valid_o !== 1'b1 || resp_way_mask_o !== 2'b11 || resp_rdata_o !== 64'h0) begin
            n_bad++;
            $display("FAIL init_read: valid=%b mask=%b data=%h, expected 1 11 0", resp_valid_o, resp_way_mask_o, resp_rdata_o);
        end
        next_cycle();
    endtask

    task automatic test_write_read();
        resp_ready_i = 1'b1;
        drive_write(2'b10, 4'd3, 32'hA5A5A5A5, 4'hF);
        @(negedge clk_i);
        n_vec++;
        if (req_ready_o !== 1'b1 || sram_req_o !== 2'b10 || sram_we_o !== 1'b1 || sram_addr_o !== 4'd3) begin
            n_bad++;
            $display("FAIL wr_cmd: ready=%b req=%b we=%b addr=%0d, expected 1 10 1 3", req_ready_o, sram_req_o, sram_we_o, sram_addr_o);
        end
        next_cycle();
        drive_read(2'b10, 4'd3);
        @(negedge clk_i);
        n_vec++;
        if (req_ready_o !== 1'b1 || sram_req_o !== 2'b10 || sram_we_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_cmd: ready=%b req=%b we=%b, expected 1 10 0", req_ready_o, sram_req_o, sram_we_o);
        end
        next_cycle();
        drive_idle();
        @(negedge clk_i);
        n_vec++;
        if (resp_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_t1: valid=%b, expected 0", resp_valid_o);
        end
        next_cycle();
        @(negedge clk_i);
        n_vec++;
        if (resp_valid_o !== 1'b1 || resp_way_mask_o !== 2'b10 || resp_rdata_o !== D3) begin
            n_bad++;
            $display("FAIL rd_t2: valid=%b mask=%b data=%h, expected 1 10 %h", resp_valid_o, resp_way_mask_o, resp_rdata_o, D3);
        end
        next_cycle();
        @(negedge clk_i);
        n_vec++;
        if (resp_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_t3: valid=%b, expected 0", resp_valid_o);
        end
        next_cycle();
    endtask

    task automatic test_byte_enable();
        drive_write(2'b01, 4'd5, 32'hFFFFFFFF, 4'hF);
        next_cycle();
        drive_write(2'b01, 4'd5, 32'h00000000, 4'h1);
        @(negedge clk_i);
        n_vec++;
        if (sram_be_o !== 4'h1 || sram_req_o !== 2'b01) begin
            n_bad++;
            $display("FAIL be_cmd: be=%h req=%b, expected 1 01", sram_be_o, sram_req_o);
        end
        next_cycle();
        drive_read(2'b01, 4'd5);
        next_cycle();
        drive_idle();
        next_cycle();
        @(negedge clk_i);
        n_vec++;
        if (resp_valid_o !== 1'b1 || resp_way_mask_o !== 2'b01 || resp_rdata_o !== D5) begin
            n_bad++;
            $display("FAIL be_read: valid=%b mask=%b data=%h, expected 1 01 %h", resp_valid_o, resp_way_mask_o, resp_rdata_o, D5);
        end
        next_cycle();
    endtask

    task automatic test_zero_mask();
        drive_read(2'b00, 4'd3);
        @(negedge clk_i);
        n_vec++;
        if (req_ready_o !== 1'b1 || sram_req_o !== 2'b00) begin
            n_bad++;
            $display("FAIL zmask_cmd: ready=%b req=%b, expected 1 00", req_ready_o, sram_req_o);
        end
        next_cycle();
        drive_idle();
        next_cycle();
        @(negedge clk_i);
        n_vec++;
        if (resp_valid_o !== 1'b1 || resp_way_mask_o !== 2'b00 || resp_rdata_o !== 64'h0) begin
            n_bad++;
            $display("FAIL zmask_resp: valid=%b mask=%b data=%h, expected 1 00 0", resp_valid_o, resp_way_mask_o, resp_rdata_o);
        end
        next_cycle();
    endtask

    task automatic test_backpressure();
        // Per cycle: request driven, resp_ready, expected req_ready, resp_valid, head entry.
        logic [3:0]  addr_t [10] = '{4'd3, 4'd5, 4'd3, 4'd3, 4'd3, 4'd3, 4'd5, 4'd0, 4'd0, 4'd0};
        logic        vld_t  [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        logic        rrdy_t [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        logic        erdy_t [10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
        logic        evld_t [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
        logic [63:0] edat_t [10] = '{64'h0, 64'h0, D3, D3, D3, D3, D5, D3, D5, 64'h0};
        for (int c = 0; c < 10; c++) begin
            if (vld_t[c]) drive_read(2'b11, addr_t[c]);
            else drive_idle();
            resp_ready_i = rrdy_t[c];
            @(negedge clk_i);
            n_vec++;
            if (req_ready_o !== erdy_t[c] || resp_valid_o !== evld_t[c] ||
                (evld_t[c] && (resp_way_mask_o !== 2'b11 || resp_rdata_o !== edat_t[c]))) begin
                n_bad++;
                $display("FAIL backpressure[%0d]: ready=%b valid=%b mask=%b data=%h, expected %b %b 11 %h",
                         c, req_ready_o, resp_valid_o, resp_way_mask_o, resp_rdata_o, erdy_t[c], evld_t[c], edat_t[c]);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        resp_ready_i = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c < 8) drive_read(2'b11, (c % 2 == 1) ? 4'd5 : 4'd3);
            else drive_idle();
            @(negedge clk_i);
            n_vec++;
            if (c < 8 && req_ready_o !== 1'b1) begin
                n_bad++;
                $display("FAIL stream_ready[%0d]: ready=%b, expected 1", c, req_ready_o);
            end
            if (c >= 2 && c < 10) begin
                if (resp_valid_o !== 1'b1 || resp_rdata_o !== (((c - 2) % 2 == 1) ? D5 : D3)) begin
                    n_bad++;
                    $display("FAIL stream_resp[%0d]: valid=%b data=%h, expected 1 %h",
                             c, resp_valid_o, resp_rdata_o, ((c - 2) % 2 == 1) ? D5 : D3);
                end
            end else if (resp_valid_o !== 1'b0) begin
                n_bad++;
                $display("FAIL stream_idle[%0d]: valid=%b, expected 0", c, resp_valid_o);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        resp_ready_i = 1'b0;
        drive_read(2'b10, 4'd3);
        next_cycle();
        drive_idle();
        next_cycle();
        @(negedge clk_i);
        n_vec++;
        if (resp_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_buffered: valid=%b, expected 1", resp_valid_o);
        end
        #1 rst_i = 1'b1;
        #1;
        n_vec++;
        if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b0 || sram_req_o !== 2'b00) begin
            n_bad++;
            $display("FAIL rstmid_in_reset: valid=%b ready=%b req=%b, expected 0 0 00", resp_valid_o, req_ready_o, sram_req_o);
        end
        next_cycle();
        rst_i = 1'b0;
`ifdef STD_NBDCACHE_DATA_PORT_INIT_EN
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            n_vec++;
            if (sram_addr_o !== 4'(i) || resp_valid_o !== 1'b0) begin
                n_bad++;
                $display("FAIL rstmid_sweep1[%0d]: addr=%0d valid=%b, expected %0d 0", i, sram_addr_o, resp_valid_o, i);
            end
            if (i < 7) next_cycle();
        end
        #1 rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
        for (int i = 0; i < NW; i++) begin
            @(negedge clk_i);
            n_vec++;
            if (sram_addr_o !== 4'(i) || sram_req_o !== 2'b11 || init_done_o !== 1'b0 || resp_valid_o !== 1'b0) begin
                n_bad++;
                $display("FAIL rstmid_sweep2[%0d]: addr=%0d req=%b done=%b valid=%b, expected %0d 11 0 0",
                         i, sram_addr_o, sram_req_o, init_done_o, resp_valid_o, i);
            end
            next_cycle();
        end
`endif
        resp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            n_vec++;
            if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || init_done_o !== 1'b1) begin
                n_bad++;
                $display("FAIL rstmid_after[%0d]: valid=%b ready=%b done=%b, expected 0 1 1", i, resp_valid_o, req_ready_o, init_done_o);
            end
            next_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_byte_enable();
        test_zero_mask();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
